// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;
    localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a} for a common-anode display.
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    // Pure lookup; the caller gates the result and flops it.
    always_comb begin
        seg_c = 7'h7F;
        case (hex)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed display scanner with tear-free value staging,
// per-slot blanking gap and leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [15:0]           value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_en,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned       CNT_W      = $clog2(TICKS_PER_DIGIT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);
    localparam scan_state_t       SLOT_START = (BLANK_TICKS == 0) ? S_DRIVE : S_BLANK;
    localparam logic [1:0]        LAST_IDX   = 2'(NUM_DIGITS - 1);

    // Reject illegal slot timing at elaboration.
    if (TICKS_PER_DIGIT < 2) begin : g_chk_ticks
        $error("seg7_scan_ctrl: TICKS_PER_DIGIT must be at least 2");
    end
    if (BLANK_TICKS >= TICKS_PER_DIGIT) begin : g_chk_blank
        $error("seg7_scan_ctrl: BLANK_TICKS must be below TICKS_PER_DIGIT");
    end

    scan_state_t      state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [1:0]       idx, nxt_idx;
    logic [15:0]      staged, shadow;

    logic [3:0]       nib_c;
    logic [6:0]       dec_c;
    logic             lz_c;
    logic             frame_end_c;
    logic             frame_next_c;

    // Next scan position: slot counter spans blank plus drive, digit advances at slot end.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        if (!en) begin
            nxt_state = S_OFF;
            nxt_cnt   = '0;
            nxt_idx   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    nxt_state = SLOT_START;
                end
                S_BLANK: begin
                    nxt_cnt = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        nxt_state = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        nxt_cnt   = '0;
                        nxt_idx   = idx + 2'd1;
                        nxt_state = SLOT_START;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    nxt_state = S_OFF;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                end
            endcase
        end
    end

    // Frame end now, and frame end on the coming cycle (for the aligned registered pulse).
    assign frame_end_c  = (state == S_DRIVE) && (idx == LAST_IDX) && (cnt == CNT_LAST);
    assign frame_next_c = (nxt_state == S_DRIVE) && (nxt_idx == LAST_IDX) && (nxt_cnt == CNT_LAST);

    // Select the current digit's nibble and decide leading-zero suppression.
    assign nib_c = shadow[{idx, 2'b00} +: 4];

    always_comb begin
        lz_c = 1'b0;
        case (idx)
            2'd1:    lz_c = (shadow[15:4]  == 12'h000);
            2'd2:    lz_c = (shadow[15:8]  == 8'h00);
            2'd3:    lz_c = (shadow[15:12] == 4'h0);
            default: lz_c = 1'b0;
        endcase
        lz_c = lz_c && lz_blank;
    end

    hex_to_7seg u_dec (
        .hex   (nib_c),
        .seg_c (dec_c)
    );

    // Scan state, value staging/commit and registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OFF;
            cnt        <= '0;
            idx        <= '0;
            staged     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            frame_done <= frame_next_c;

            if (load) begin
                staged <= value;
            end
            if (frame_end_c) begin
                if (load) begin
                    shadow <= value;
                end else if (pending) begin
                    shadow <= staged;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            if (state == S_DRIVE) begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= lz_c ? SEG_OFF : dec_c;
                dp  <= ~dp_en[idx];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 8-cycle slots and a 2-cycle blank.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_en;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .TICKS_PER_DIGIT (8),
        .BLANK_TICKS     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .load       (load),
        .dp_en      (dp_en),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Active-low segment patterns, written out from the digit shapes.
    function automatic logic [6:0] hexseg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Checks 32 output cycles starting at digit 0's first blank cycle.
    // Optionally pulses load after output cycle load_at.
    task automatic check_frame(input string name, input logic [15:0] v, input logic lz,
                               input logic [3:0] dpe, input logic pend_in,
                               input int load_at, input logic [15:0] load_val);
        logic        pend;
        logic        ldprev;
        logic [13:0] got;
        logic [13:0] exp;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        int          d;
        int          c;
        pend     = pend_in;
        lz_blank = lz;
        dp_en    = dpe;
        for (int i = 0; i < 32; i++) begin
            tick();
            ldprev = load;
            load   = 1'b0;
            if (i == 31) pend = 1'b0;
            else if (ldprev) pend = 1'b1;
            d = i / 8;
            c = i % 8;
            if (c < 2) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << d);
                e_seg = (lz && d > 0 && (v >> (4 * d)) == 16'h0) ? 7'h7F : hexseg(4'((v >> (4 * d)) & 16'hF));
                e_dp  = ~dpe[d];
            end
            exp = {e_an, e_seg, e_dp, (i == 30), pend};
            got = {an, seg, dp, frame_done, pending};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s[%0d] {an,seg,dp,fd,pend} got %h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
                         name, i, an, seg, dp, frame_done, pending,
                         e_an, e_seg, e_dp, (i == 30), pend);
            end
            if (i == load_at) begin
                load  = 1'b1;
                value = load_val;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        en    = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        tick();
        tick();
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        checks++;
        if ({an, seg, dp, pending, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got an=%h seg=%h dp=%b pend=%b fd=%b expected F/7f/1/0/0",
                     an, seg, dp, pending, frame_done);
        end
        tick();
        checks++;
        if ({an, seg, pending} !== {4'hF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle got an=%h seg=%h pend=%b expected F/7f/0", an, seg, pending);
        end
    endtask

    task automatic test_scan;
        value = 16'h1234;
        load  = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pend_rise got %b expected 1", pending);
        end
        en = 1'b1;
        tick();
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL en_first got an=%h expected F", an);
        end
        check_frame("frame_old0", 16'h0000, 1'b0, 4'h0, 1'b1, -1, 16'h0);
        check_frame("frame_1234", 16'h1234, 1'b0, 4'h0, 1'b0, 10, 16'hABCD);
    endtask

    task automatic test_tear_free_and_coincident;
        check_frame("frame_abcd", 16'hABCD, 1'b0, 4'h0, 1'b0, 30, 16'h00F0);
        check_frame("frame_00f0_lz", 16'h00F0, 1'b1, 4'h0, 1'b0, 30, 16'h0005);
    endtask

    task automatic test_lz;
        check_frame("frame_0005_lz", 16'h0005, 1'b1, 4'h0, 1'b0, 30, 16'h0000);
        check_frame("frame_0000_lz", 16'h0000, 1'b1, 4'h0, 1'b0, -1, 16'h0);
    endtask

    task automatic test_dp_en_drop;
        check_frame("frame_dp", 16'h0000, 1'b0, 4'b0100, 1'b0, -1, 16'h0);
        for (int k = 0; k < 20; k++) tick();
        en = 1'b0;
        tick();
        checks++;
        if ({an, dp} !== {4'hB, 1'b0}) begin
            errors++;
            $display("FAIL drop_hold got an=%h dp=%b expected B/0", an, dp);
        end
        tick();
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL drop_off got an=%h seg=%h dp=%b expected F/7f/1", an, seg, dp);
        end
        value = 16'h1234;
        load  = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({pending, an} !== {1'b1, 4'hF}) begin
            errors++;
            $display("FAIL off_load got pend=%b an=%h expected 1/F", pending, an);
        end
        en = 1'b1;
        tick();
        check_frame("restart", 16'h0000, 1'b0, 4'b0100, 1'b1, -1, 16'h0);
        check_frame("after_restart", 16'h1234, 1'b0, 4'h0, 1'b0, -1, 16'h0);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 10; k++) tick();
        value = 16'hABCD;
        load  = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_pend got %b expected 1", pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({an, seg, dp, pending, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got an=%h seg=%h dp=%b pend=%b fd=%b expected F/7f/1/0/0",
                     an, seg, dp, pending, frame_done);
        end
        tick();
        check_frame("post_reset", 16'h0000, 1'b0, 4'h0, 1'b0, -1, 16'h0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_en    = 4'h0;
        lz_blank = 1'b0;
        test_reset();
        test_scan();
        test_tear_free_and_coincident();
        test_lz();
        test_dp_en_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
